// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result pipeline stage.
//   WIDTH   : datapath width (flag logic is built for 64 bits only)
//   state_e : skid-buffer occupancy state
//   entry_t : one buffered result with its flags, computed at capture
package alu_result_stage_pkg;

   localparam int unsigned WIDTH = 64;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_e;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             negative;
      logic             carry;
      logic             overflow;
   } entry_t;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// alu_flag_gen: combinational flag derivation for one ALU result.
// Ports:
//   result_i   : ALU result
//   is_arith_i : 1 = add/sub, 0 = logic op
//   carry_i    : raw adder carry-out
//   overflow_i : raw adder signed overflow
//   entry_o    : packed entry {result, zero, negative, carry, overflow}
module alu_flag_gen
   import alu_result_stage_pkg::*;
(
   input  logic [WIDTH-1:0] result_i,
   input  logic             is_arith_i,
   input  logic             carry_i,
   input  logic             overflow_i,
   output entry_t           entry_o
);

   always_comb begin
      entry_o          = '0;
      entry_o.result   = result_i;
      entry_o.zero     = ~(|result_i);
      entry_o.negative = result_i[WIDTH-1];
      // Carry/overflow come straight from the adder even during logic ops,
      // so they are only meaningful when the op was arithmetic.
      entry_o.carry    = carry_i & is_arith_i;
      entry_o.overflow = overflow_i & is_arith_i;
   end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: pipeline register after the 64-bit ALU. Captures the
// result with derived flags and hands it to writeback over valid/ready,
// through a 2-entry skid buffer so in_ready is purely registered.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : ALU-side handshake (in_ready registered)
//   in_result, in_is_arith, in_carry, in_overflow : ALU result and raw flags
//   out_valid/out_ready: writeback-side handshake
//   out_result, out_zero, out_negative, out_carry, out_overflow : head entry
//   ovf_clr, sticky_ovf: only with ALU_RESULT_STAGE_STICKY_OVF_EN defined;
//                        sticky overflow seen on any emitted entry
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int unsigned WIDTH = alu_result_stage_pkg::WIDTH,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_is_arith,
   input  logic             in_carry,
   input  logic             in_overflow,
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   input  logic             ovf_clr,
   output logic             sticky_ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_negative,
   output logic             out_carry,
   output logic             out_overflow
);

   if (DEPTH != 2) begin : g_bad_depth
      $error("alu_result_stage: DEPTH must be 2");
   end
   if (WIDTH != alu_result_stage_pkg::WIDTH) begin : g_bad_width
      $error("alu_result_stage: WIDTH must be 64");
   end

   state_e state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   in_ready_q, in_ready_d;
   logic   accept, emit;

   alu_flag_gen u_flag_gen (
      .result_i   (in_result),
      .is_arith_i (in_is_arith),
      .carry_i    (in_carry),
      .overflow_i (in_overflow),
      .entry_o    (in_entry)
   );

   assign accept = in_valid & in_ready_q;
   assign emit   = (state_q != EMPTY) & out_ready;

   // main_q always holds the head entry; skid_q only the second one.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               main_d = in_entry;
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = FULL;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready_q is low here, so no accept can coincide.
            if (emit) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Registered from next state: no combinational path from out_ready.
   assign in_ready_d = (state_d != FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = (state_q != EMPTY);
   assign out_result   = main_q.result;
   assign out_zero     = main_q.zero;
   assign out_negative = main_q.negative;
   assign out_carry    = main_q.carry;
   assign out_overflow = main_q.overflow;

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // Set has priority over a simultaneous clear.
   assign sticky_d = (emit & main_q.overflow) | (sticky_q & ~ovf_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vectors plus a
// FIFO scoreboard that checks every cycle's handshake and head entry.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_result = '0;
   logic        in_is_arith = 1'b0;
   logic        in_carry = 1'b0;
   logic        in_overflow = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_result;
   logic        out_zero, out_negative, out_carry, out_overflow;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
   logic        ovf_clr = 1'b0;
   logic        sticky_ovf;
`endif

   always #5 clk = ~clk;

   alu_result_stage u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_is_arith  (in_is_arith),
      .in_carry     (in_carry),
      .in_overflow  (in_overflow),
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      .ovf_clr      (ovf_clr),
      .sticky_ovf   (sticky_ovf),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_negative (out_negative),
      .out_carry    (out_carry),
      .out_overflow (out_overflow)
   );

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [67:0] model(input logic [63:0] r, input logic a, input logic c,
                                         input logic o);
      return {r, (r == 64'd0), r[63], c & a, o & a};
   endfunction

   // Scoreboard: entries the DUT currently holds, head first.
   logic [67:0] sb[$];
   logic [63:0] em_log[$];
   int unsigned acc_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         check_eq("in_ready", 68'(in_ready), 68'(sb.size() < 2));
         check_eq("out_valid", 68'(out_valid), 68'(sb.size() != 0));
         if (out_valid && sb.size() != 0)
            check_eq("out_entry", {out_result, out_zero, out_negative, out_carry, out_overflow},
                     sb[0]);
         if (out_valid && out_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            em_log.push_back(out_result);
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_result, in_is_arith, in_carry, in_overflow));
            acc_cnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one result and hold it until accepted; leaves in_valid high.
   task automatic send(input logic [63:0] r, input logic a, input logic c, input logic o);
      int unsigned start = acc_cnt;
      int unsigned n = 0;
      in_valid    = 1'b1;
      in_result   = r;
      in_is_arith = a;
      in_carry    = c;
      in_overflow = o;
      while (acc_cnt == start && n < 20) begin
         cyc();
         n++;
      end
      check_eq("send_accepted", 68'(acc_cnt != start), 68'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [63:0] ValA = 64'h0000_0000_0000_00A1;
   localparam logic [63:0] ValB = 64'hFFFF_0000_0000_00B2;
   localparam logic [63:0] ValC = 64'h0123_4567_89AB_CDEF;

   initial begin
      int unsigned start;
      int unsigned n;
      int unsigned last_acc;

      // Reset with in_valid asserted: nothing may be captured.
      in_valid  = 1'b1;
      in_result = 64'hDEAD_BEEF_0000_0001;
      in_is_arith = 1'b1;
      in_carry  = 1'b1;
      in_overflow = 1'b1;
      out_ready = 1'b1;
      repeat (2) cyc();
      check_eq("rst_out_valid", 68'(out_valid), 68'd0);
      check_eq("rst_in_ready", 68'(in_ready), 68'd1);
      check_eq("rst_out_entry", {out_result, out_zero, out_negative, out_carry, out_overflow},
               68'd0);
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      check_eq("rst_sticky", 68'(sticky_ovf), 68'd0);
`endif
      em_log.delete();
      rst   = 1'b0;
      start = acc_cnt;
      cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      check_eq("rst_one_accept", 68'(acc_cnt - start), 68'd1);
      check_eq("rst_one_emit", 68'(em_log.size()), 68'd1);

      // Streaming: zero logic result then most-negative arith result.
      send(64'h0, 1'b0, 1'b0, 1'b0);
      in_result   = 64'h8000_0000_0000_0000;
      in_is_arith = 1'b1;
      in_carry    = 1'b1;
      in_overflow = 1'b1;
      @(negedge clk);
      check_eq("stream0_zn", {out_zero, out_negative, out_carry, out_overflow}, 68'b1000);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("stream1_flags", {out_result, out_zero, out_negative, out_carry, out_overflow},
               {64'h8000_0000_0000_0000, 4'b0111});
      cyc();

      // Logic ops mask carry/overflow.
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("logic_mask", {out_zero, out_negative, out_carry, out_overflow}, 68'b0100);
      repeat (2) cyc();

      // Backpressure: A, B fill the buffer, C must wait.
      em_log.delete();
      out_ready = 1'b0;
      send(ValA, 1'b1, 1'b0, 1'b0);
      send(ValB, 1'b0, 1'b0, 1'b0);
      in_result   = ValC;
      in_is_arith = 1'b1;
      in_carry    = 1'b1;
      in_overflow = 1'b0;
      check_eq("bp_in_ready_low", 68'(in_ready), 68'd0);
      start = acc_cnt;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_stall_head", 68'(out_result), 68'(ValA));
         cyc();
      end
      check_eq("bp_c_not_taken", 68'(acc_cnt - start), 68'd0);
      out_ready = 1'b1;
      n = 0;
      while (acc_cnt == start && n < 20) begin
         cyc();
         n++;
      end
      check_eq("bp_c_accepted", 68'(acc_cnt - start), 68'd1);
      in_valid = 1'b0;
      repeat (4) cyc();
      check_eq("bp_emit_count", 68'(em_log.size()), 68'd3);
      if (em_log.size() == 3) begin
         check_eq("bp_order_a", 68'(em_log[0]), 68'(ValA));
         check_eq("bp_order_b", 68'(em_log[1]), 68'(ValB));
         check_eq("bp_order_c", 68'(em_log[2]), 68'(ValC));
      end

      // Reset while full drops both entries.
      out_ready = 1'b0;
      send(64'h11, 1'b1, 1'b0, 1'b1);
      send(64'h22, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      em_log.delete();
      check_eq("midrst_out_valid", 68'(out_valid), 68'd0);
      check_eq("midrst_in_ready", 68'(in_ready), 68'd1);
      out_ready = 1'b1;
      repeat (3) cyc();
      check_eq("midrst_no_emit", 68'(em_log.size()), 68'd0);

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
      check_eq("sticky_after_rst", 68'(sticky_ovf), 68'd0);
      send(64'h5, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      cyc();
      check_eq("sticky_set", 68'(sticky_ovf), 68'd1);
      send(64'h6, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      ovf_clr  = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      check_eq("sticky_set_wins", 68'(sticky_ovf), 68'd1);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      check_eq("sticky_cleared", 68'(sticky_ovf), 68'd0);
`endif

      // Random stress; held data is never changed before it is accepted.
      last_acc = acc_cnt;
      for (int i = 0; i < 10000; i++) begin
         if (!in_valid || acc_cnt != last_acc) begin
            in_valid    = ($urandom_range(3) != 0);
            in_is_arith = $urandom_range(1);
            in_carry    = $urandom_range(1);
            in_overflow = $urandom_range(1);
            case ($urandom_range(3))
               0:       in_result = 64'h0;
               1:       in_result = {1'b1, 31'($urandom), 32'($urandom)};
               default: in_result = {32'($urandom), 32'($urandom)};
            endcase
         end
         last_acc  = acc_cnt;
         out_ready = ($urandom_range(2) != 0);
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cyc();
      check_eq("drain_empty", 68'(sb.size()), 68'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline register directly downstream of the 64-bit ALU datapath (adder plus bitwise AND/OR/XOR units).
- Captures the ALU result and raw carry/overflow, derives zero/negative flags, and presents them to writeback over a valid/ready handshake.
- A 2-entry skid buffer decouples ALU issue from writeback stalls, so in_ready is a registered signal with no combinational path from out_ready.

Parameters:
- WIDTH, 64, datapath width in bits; the flag logic is built for 64 only.
- DEPTH, 2, skid entries; fixed at 2, anything else is a compile-time error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept (registered)
- in_result  in  WIDTH  ALU result
- in_is_arith  in  1  1 = add/sub, 0 = logic op
- in_carry  in  1  adder carry-out
- in_overflow  in  1  adder signed overflow
- out_valid  out  1  output entry valid
- out_ready  in  1  writeback accepts
- out_result  out  WIDTH  registered result
- out_zero  out  1  out_result == 0
- out_negative  out  1  out_result[WIDTH-1]
- out_carry  out  1  carry, arith only
- out_overflow  out  1  overflow, arith only

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: state=EMPTY, out_valid=0, in_ready=1, out_result=0, and all flags=0. A reset mid-transfer drops both entries; no partial output.
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Emit occurs when out_valid && out_ready.
  - out_* must stay stable while out_valid && !out_ready.
- Flags are computed at capture and stored with each entry:
  - zero = OR-reduction of in_result, inverted.
  - negative = in_result[63].
  - carry = in_carry & in_is_arith; overflow = in_overflow & in_is_arith. Logic ops always report 0 for both.
- State machine (the main register feeds out_*, the skid register holds the overflow entry):
  - EMPTY:
    - accept: load main, go to ONE.
  - ONE:
    - accept & emit: load main, stay in ONE.
    - accept & !emit: load skid, go to FULL.
    - emit & !accept: go to EMPTY.
  - FULL:
    - emit: skid moves to main, go to ONE. No accept is possible because in_ready=0.
- in_ready = (next state != FULL), registered.
- Latency: an accept in cycle N gives out_valid in cycle N+1 when empty. Throughput is 1 per cycle when out_ready is held high.
- Data ordering is strictly FIFO; no entry is ever dropped or duplicated.
- in_valid while in_ready=0 is ignored. The ALU must hold its data until the transfer happens.

Optional Feature:
- Macro ALU_RESULT_STAGE_STICKY_OVF_EN.
- When defined, two extra ports are added:
  - ovf_clr  in  1
  - sticky_ovf  out  1
- sticky_ovf is set the cycle after any emit with out_overflow=1.
- A synchronous ovf_clr clears it. If set and clear happen in the same cycle, set wins. rst clears it to 0.
- When not defined, neither port exists and no sticky logic is built.

Decomposition:
- Shared package holds:
  - WIDTH=64.
  - A state enum: EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
  - A packed entry struct {result[63:0], zero, negative, carry, overflow}.
- One sub-module, alu_flag_gen: combinational OR-reduction zero flag, negative, and arith masking. It is instantiated once at the input.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1. Expect out_valid=0, in_ready=1, out_result=0. After release, exactly one accept occurs.
- Streaming: send in_result=0x0 (logic), then 0x8000_0000_0000_0000 (arith, carry=1, ovf=1), with out_ready=1. Expect outputs on consecutive cycles:
  - zero=1, negative=0.
  - then negative=1, carry=1, overflow=1.
- Logic masking: in_is_arith=0 with in_carry=1 and in_overflow=1. Expect out_carry=0 and out_overflow=0.
- Backpressure: hold out_ready=0 and send 3 results A, B, C. Expect in_ready=0 after B and C not accepted. Release out_ready; expect A, B, C in order with outputs stable while stalled.
- Random stress: random in_valid/out_ready for 10k cycles against a scoreboard. Expect no loss, no duplication, in order, and flags matching the reference model.
- Optional feature (ALU_RESULT_STAGE_STICKY_OVF_EN): emit an overflow result. Expect sticky_ovf=1 the next cycle. Pulse ovf_clr together with a second overflow emit; expect sticky_ovf stays 1. Then pulse ovf_clr alone; expect sticky_ovf goes to 0.
